// File: rtl/tlb_ctrl_if.sv
// TLB entry type and the maintenance-op / response bundle shared by tlb_ctrl and its requester.
package tlb_ctrl_pkg;
   typedef struct packed {
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic        g;
      logic [9:0]  asid;
      logic        e;
      logic [19:0] ppn0;
      logic [1:0]  plv0;
      logic [1:0]  mat0;
      logic        d0;
      logic        v0;
      logic [19:0] ppn1;
      logic [1:0]  plv1;
      logic [1:0]  mat1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;
endpackage

interface tlb_ctrl_if #(parameter int IDW = 4) ();
   import tlb_ctrl_pkg::*;

   logic             op_valid;
   logic             op_ready;
   logic [2:0]       op_type;
   logic [IDW-1:0]   op_index;
   tlb_entry_t       op_entry;
   logic [18:0]      op_vppn;
   logic [9:0]       op_asid;
   logic [4:0]       op_inv_op;
   logic [9:0]       op_inv_asid;
   logic [31:0]      op_inv_va;
   logic             resp_valid;
   logic             resp_ready;
   logic             resp_found;
   logic [IDW-1:0]   resp_index;
   tlb_entry_t       resp_entry;

   modport master (
      output op_valid, op_type, op_index, op_entry, op_vppn, op_asid,
             op_inv_op, op_inv_asid, op_inv_va, resp_ready,
      input  op_ready, resp_valid, resp_found, resp_index, resp_entry
   );

   modport slave (
      input  op_valid, op_type, op_index, op_entry, op_vppn, op_asid,
             op_inv_op, op_inv_asid, op_inv_va, resp_ready,
      output op_ready, resp_valid, resp_found, resp_index, resp_entry
   );
endinterface

// File: rtl/tlb_ctrl.sv
// TLB maintenance sequencer: runs one SRCH/RD/WR/FILL/INV op at a time against the TLB ports.
// Optional macro TLB_FILL_LFSR_EN selects an LFSR fill index instead of the round-robin counter.
module tlb_ctrl
   import tlb_ctrl_pkg::*;
#(
   parameter int TLBNUM   = 16,
   parameter int TLBIDLEN = $clog2(TLBNUM)
) (
   input  logic                clk,
   input  logic                reset,
   tlb_ctrl_if.slave           op,
   input  logic [18:0]         lsu_vppn,
   input  logic [9:0]          lsu_asid,
   output logic                lsu_stall,
   output logic [18:0]         s1_vppn,
   output logic [9:0]          s1_asid,
   input  logic                s1_found,
   input  logic [TLBIDLEN-1:0] s1_index,
   output logic                we,
   output logic [TLBIDLEN-1:0] w_index,
   output tlb_entry_t          w_entry,
   output logic [TLBIDLEN-1:0] r_index,
   input  tlb_entry_t          r_entry,
   output logic                invtlb_valid,
   output logic [4:0]          invtlb_op,
   output logic [9:0]          invtlb_asid,
   output logic [31:0]         invtlb_va
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SRCH1 = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [2:0]          op_type;
      logic [TLBIDLEN-1:0] index;
      tlb_entry_t          entry;
      logic [18:0]         vppn;
      logic [9:0]          asid;
      logic [4:0]          inv_op;
      logic [9:0]          inv_asid;
      logic [31:0]         inv_va;
   } op_lat_t;

   state_t              state_q, state_d;
   op_lat_t             lat_q, lat_d;
   logic                resp_found_q, resp_found_d;
   logic [TLBIDLEN-1:0] resp_index_q, resp_index_d;
   tlb_entry_t          resp_entry_q, resp_entry_d;
   logic [TLBIDLEN-1:0] fill_idx_s;
   logic                fill_adv_s;
   logic                we_s, inv_valid_s, stall_s;
   logic [TLBIDLEN-1:0] w_index_s;
   logic [18:0]         s1_vppn_s;
   logic [9:0]          s1_asid_s;

   // Next-state, response capture and TLB port strobes
   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      resp_found_d = resp_found_q;
      resp_index_d = resp_index_q;
      resp_entry_d = resp_entry_q;
      fill_adv_s   = 1'b0;
      we_s         = 1'b0;
      inv_valid_s  = 1'b0;
      stall_s      = 1'b0;
      w_index_s    = lat_q.index;
      s1_vppn_s    = lsu_vppn;
      s1_asid_s    = lsu_asid;
      case (state_q)
         ST_IDLE: begin
            if (op.op_valid) begin
               lat_d   = '{op_type:  op.op_type,   index:    op.op_index,
                           entry:    op.op_entry,  vppn:     op.op_vppn,
                           asid:     op.op_asid,   inv_op:   op.op_inv_op,
                           inv_asid: op.op_inv_asid, inv_va: op.op_inv_va};
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_d      = ST_RESP;
            resp_found_d = 1'b0;
            resp_index_d = '0;
            resp_entry_d = '0;
            case (lat_q.op_type)
               OP_SRCH: begin
                  s1_vppn_s    = lat_q.vppn;
                  s1_asid_s    = lat_q.asid;
                  stall_s      = 1'b1;
                  resp_found_d = s1_found;
                  state_d      = ST_SRCH1;
               end
               OP_RD: begin
                  resp_entry_d = r_entry;
                  resp_index_d = lat_q.index;
               end
               OP_WR: begin
                  we_s         = 1'b1;
                  resp_index_d = lat_q.index;
               end
               OP_FILL: begin
                  we_s         = 1'b1;
                  w_index_s    = fill_idx_s;
                  resp_index_d = fill_idx_s;
                  fill_adv_s   = 1'b1;
               end
               OP_INV: begin
                  inv_valid_s = 1'b1;
               end
               default: begin
                  state_d = ST_RESP;
               end
            endcase
         end
         ST_SRCH1: begin
            // TLB match index is registered, so it lands one cycle after s1_found
            resp_index_d = s1_index;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (op.resp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM, latched op and response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         lat_q        <= '0;
         resp_found_q <= 1'b0;
         resp_index_q <= '0;
         resp_entry_q <= '0;
      end else begin
         state_q      <= state_d;
         lat_q        <= lat_d;
         resp_found_q <= resp_found_d;
         resp_index_q <= resp_index_d;
         resp_entry_q <= resp_entry_d;
      end
   end

`ifdef TLB_FILL_LFSR_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // LFSR state register
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= 16'h0001;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign fill_idx_s = lfsr_q[TLBIDLEN-1:0];
`else
   logic [TLBIDLEN-1:0] fill_cnt_q, fill_cnt_d;

   // Round-robin fill pointer; wraps naturally because TLBNUM is a power of two
   always_comb begin
      if (fill_adv_s) begin
         fill_cnt_d = fill_cnt_q + TLBIDLEN'(1);
      end else begin
         fill_cnt_d = fill_cnt_q;
      end
   end

   // Fill pointer register
   always_ff @(posedge clk) begin
      if (reset) begin
         fill_cnt_q <= '0;
      end else begin
         fill_cnt_q <= fill_cnt_d;
      end
   end

   assign fill_idx_s = fill_cnt_q;
`endif

   // Reset masks strobes immediately, even while the FSM still sits in EXEC
   assign we           = we_s & ~reset;
   assign invtlb_valid = inv_valid_s & ~reset;
   assign lsu_stall    = stall_s & ~reset;
   assign w_index      = w_index_s;
   assign w_entry      = lat_q.entry;
   assign r_index      = lat_q.index;
   assign s1_vppn      = s1_vppn_s;
   assign s1_asid      = s1_asid_s;
   assign invtlb_op    = lat_q.inv_op;
   assign invtlb_asid  = lat_q.inv_asid;
   assign invtlb_va    = lat_q.inv_va;

   assign op.op_ready   = (state_q == ST_IDLE) & ~reset;
   assign op.resp_valid = (state_q == ST_RESP) & ~reset;
   assign op.resp_found = resp_found_q & ~reset;
   assign op.resp_index = reset ? '0 : resp_index_q;
   assign op.resp_entry = reset ? '0 : resp_entry_q;

endmodule
